// File: rtl/layer_serializer.sv
// layer_serializer: captures a full layer of neuron results and streams them one word per cycle.
// Define LAYER_SERIALIZER_ARGMAX_EN to build the running signed argmax over each stream.
module layer_serializer #(
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] neuron_data,
    input  logic [NUM_NEURON-1:0]            neuron_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overflow,
    output logic                             valid_err,
    output logic [$clog2(NUM_NEURON)-1:0]    class_idx,
    output logic [DATA_WIDTH-1:0]            class_max,
    output logic                             class_valid
);
    localparam int CW = $clog2(NUM_NEURON);
    localparam logic [CW-1:0] LAST = CW'(NUM_NEURON - 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]         cnt, cnt_inc;
    logic [DATA_WIDTH-1:0] shadow [NUM_NEURON];
    logic                  all_valid, part_valid, at_last, accept;

    assign all_valid  = &neuron_valid;
    assign part_valid = |neuron_valid & ~all_valid;
    assign at_last    = cnt == LAST;
    assign cnt_inc    = cnt + CW'(1);
    // A new layer is only taken when the shifter is idle or emitting its final word.
    assign accept     = all_valid & (state == IDLE | at_last);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = accept ? SHIFT : (state == SHIFT && at_last) ? IDLE : state;
    end

    always_comb begin
        busy      = state == SHIFT;
        out_valid = busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            out_data  <= '0;
            overflow  <= 1'b0;
            valid_err <= 1'b0;
            for (int k = 0; k < NUM_NEURON; k++) shadow[k] <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < NUM_NEURON; k++) shadow[k] <= neuron_data[k*DATA_WIDTH +: DATA_WIDTH];
                out_data <= neuron_data[DATA_WIDTH-1:0];
            end else if (busy && !at_last) begin
                out_data <= shadow[cnt_inc];
            end
            cnt <= (!accept && busy && !at_last) ? cnt_inc : '0;
            if (all_valid && !accept) overflow <= 1'b1;
            if (part_valid) valid_err <= 1'b1;
        end
    end

`ifdef LAYER_SERIALIZER_ARGMAX_EN
    logic [DATA_WIDTH-1:0] run_max, best_max;
    logic [CW-1:0]         run_idx, best_idx;
    logic                  take;

    // Strict greater-than keeps the lower index on ties; word 0 always reseeds.
    always_comb begin
        take     = cnt == '0 || $signed(out_data) > $signed(run_max);
        best_max = take ? out_data : run_max;
        best_idx = take ? cnt : run_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max     <= '0;
            run_idx     <= '0;
            class_max   <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= busy && at_last;
            if (busy) begin
                run_max <= best_max;
                run_idx <= best_idx;
            end
            if (busy && at_last) begin
                class_max <= best_max;
                class_idx <= best_idx;
            end
        end
    end
`else
    assign class_idx   = '0;
    assign class_max   = '0;
    assign class_valid = 1'b0;
`endif
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: random layer captures checked against a word-queue model of the serializer.
module tb_layer_serializer;
    localparam int NN = 4;
    localparam int DW = 16;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    localparam bit ARG = 1'b1;
`else
    localparam bit ARG = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NN*DW-1:0]  neuron_data;
    logic [NN-1:0]     neuron_valid;
    logic [DW-1:0]     out_data;
    logic              out_valid, busy, overflow, valid_err;
    logic [1:0]        class_idx;
    logic [DW-1:0]     class_max;
    logic              class_valid;

    layer_serializer #(.NUM_NEURON(NN), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .neuron_data(neuron_data), .neuron_valid(neuron_valid),
        .out_data(out_data), .out_valid(out_valid), .busy(busy), .overflow(overflow),
        .valid_err(valid_err), .class_idx(class_idx), .class_max(class_max),
        .class_valid(class_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: queue of words still to be emitted; element 0 is on the output this cycle.
    logic [DW-1:0] wq [$];
    bit            lq [$];
    int            iq [$];
    logic [DW-1:0] mq [$];
    logic [DW-1:0] m_data = '0;
    bit            m_ovf = 0, m_err = 0, m_cv = 0;
    int            m_ci = 0;
    logic [DW-1:0] m_cm = '0;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] pick [4];
        pick[0] = 16'h8000; pick[1] = 16'h7fff; pick[2] = 16'h0200; pick[3] = 16'hff00;
        return ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : DW'($urandom);
    endfunction

    task automatic model_step();
        logic [DW-1:0] w [NN];
        bit acc, last;
        int bi, ii;
        logic [DW-1:0] mm;
        if (rst) begin
            wq.delete(); lq.delete(); iq.delete(); mq.delete();
            m_data = '0; m_ovf = 0; m_err = 0; m_cv = 0; m_ci = 0; m_cm = '0;
            return;
        end
        if (|neuron_valid && !(&neuron_valid)) m_err = 1;
        acc = (&neuron_valid) && wq.size() <= 1;
        if ((&neuron_valid) && !acc) m_ovf = 1;
        m_cv = 0;
        if (wq.size() > 0) begin
            void'(wq.pop_front());
            last = lq.pop_front();
            ii = iq.pop_front();
            mm = mq.pop_front();
            if (last) begin m_cv = 1; m_ci = ii; m_cm = mm; end
        end
        if (acc) begin
            for (int k = 0; k < NN; k++) w[k] = neuron_data[k*DW +: DW];
            bi = 0;
            for (int k = 1; k < NN; k++) if ($signed(w[k]) > $signed(w[bi])) bi = k;
            for (int k = 0; k < NN; k++) begin
                wq.push_back(w[k]); lq.push_back(k == NN - 1); iq.push_back(bi); mq.push_back(w[bi]);
            end
        end
        if (wq.size() > 0) m_data = wq[0];
    endtask

    initial begin
        int r;
        logic [NN-1:0] pv;
        rst = 1'b1; neuron_valid = '0; neuron_data = '0;
        model_step();
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("out_valid", 32'(out_valid), 32'(wq.size() > 0));
            chk("busy", 32'(busy), 32'(wq.size() > 0));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("valid_err", 32'(valid_err), 32'(m_err));
            chk("class_valid", 32'(class_valid), ARG ? 32'(m_cv) : 32'd0);
            chk("class_idx", 32'(class_idx), ARG ? 32'(m_ci) : 32'd0);
            chk("class_max", 32'(class_max), ARG ? 32'(m_cm) : 32'd0);
            rst = (c < 2) || ($urandom_range(0, 79) == 0);
            for (int k = 0; k < NN; k++) neuron_data[k*DW +: DW] = rand_word();
            r = $urandom_range(0, 99);
            pv = NN'($urandom_range(1, 14));
            neuron_valid = (r < 30) ? '1 : (r < 32) ? pv : '0;
            model_step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 Parameter NUM_NEURON, default 30: neurons in the producing layer and words per output stream.
REQ-002 Parameter DATA_WIDTH, default 16: width of each neuron result word.
REQ-003 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port neuron_data, input, NUM_NEURON*DATA_WIDTH: packed neuron outputs; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-006 Port neuron_valid, input, NUM_NEURON: per-neuron output_valid pulses.
REQ-007 Port out_data, output, DATA_WIDTH: serial word to the next layer's input_data.
REQ-008 Port out_valid, output, 1: qualifies out_data; drives the next layer's input_valid.
REQ-009 Port busy, output, 1: high while a stream is in progress.
REQ-010 Port overflow, output, 1: sticky; a capture was dropped.
REQ-011 Port valid_err, output, 1: sticky; neuron_valid was partially asserted.
REQ-012 Port class_idx, output, $clog2(NUM_NEURON): argmax index (ARGMAX_EN only).
REQ-013 Port class_max, output, DATA_WIDTH: argmax value (ARGMAX_EN only).
REQ-014 Port class_valid, output, 1: one-cycle pulse qualifying class_idx/class_max (ARGMAX_EN only).

Function
REQ-015 States IDLE and SHIFT; an internal word counter cnt ranges 0..NUM_NEURON-1.
REQ-016 Capture condition: &neuron_valid; the capture latches all of neuron_data into a shadow register.
REQ-017 Capture is accepted in IDLE, or in SHIFT when cnt==NUM_NEURON-1 (last word cycle); on acceptance the next state is SHIFT with cnt=0.
REQ-018 Capture accepted in cycle N: out_valid is high in cycles N+1..N+NUM_NEURON, with no gaps and no backpressure.
REQ-019 out_data order: neuron 0 first, neuron NUM_NEURON-1 last; a registered output is driven from the shadow register indexed by cnt.
REQ-020 After the last word with no new capture, the block returns to IDLE; out_valid=0 and out_data holds its last value.
REQ-021 A back-to-back capture on the last-word cycle produces a continuous stream of 2*NUM_NEURON valid cycles.
REQ-022 A capture condition in SHIFT with cnt<NUM_NEURON-1 is dropped and sets overflow; the current stream is unaffected.
REQ-023 If |neuron_valid is set and &neuron_valid is not, valid_err is set and nothing is captured.
REQ-024 busy equals (state==SHIFT).
REQ-025 overflow and valid_err clear only on rst.

Reset
REQ-026 On rst: state=IDLE, cnt=0, out_valid=0, out_data=0, busy=0, overflow=0, valid_err=0, class_valid=0, class_idx=0, class_max=0, shadow register=0.
REQ-027 rst asserted mid-stream aborts the stream at the next edge; no further out_valid is produced; neuron_valid in the rst cycle is ignored.

Configuration
REQ-028 Macro LAYER_SERIALIZER_ARGMAX_EN defined: as each word is emitted, the block tracks the running signed maximum and its index.
REQ-029 Argmax comparison is signed two's complement; ties keep the lower index; the running maximum reinitialises from word 0 of each stream.
REQ-030 With the macro defined, class_valid pulses for one cycle in the cycle after the last out_valid of each stream, and class_idx/class_max hold until the next pulse.
REQ-031 Macro not defined: no argmax logic is built; class_idx, class_max and class_valid are tied to 0.

Verification (NUM_NEURON=4, DATA_WIDTH=16)
REQ-032 Single capture of words {0x0010,0xFFF0,0x0100,0x0005} in cycle 10 -> out_valid in cycles 11-14 with data 0x0010,0xFFF0,0x0100,0x0005; busy high cycles 11-14.
REQ-033 Second capture in cycle 14 (last word) -> out_valid continuous cycles 11-18, second data set in order; overflow stays 0.
REQ-034 Second capture in cycle 12 -> dropped, overflow=1 from cycle 13, first stream completes unchanged.
REQ-035 neuron_valid=4'b0011 -> no out_valid, valid_err=1 next cycle; a subsequent 4'b1111 capture is still accepted.
REQ-036 rst high in cycle 12 mid-stream -> out_valid=0 from cycle 13, all flags 0, state IDLE.
REQ-037 ARGMAX_EN with words {0xFF00,0x0200,0x0200,0x8000} -> class_valid in the cycle after the last word, class_idx=1, class_max=0x0200; without the macro, all class_* outputs remain 0.
